// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit: LEGv8 instruction fetch with one outstanding imem read,  |
// | a one-entry hold buffer and branch redirect/squash.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_unit #(
  parameter int N = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic         if_valid,
  input  logic         if_ready,
  output logic [31:0]  if_instr,
  output logic [N-1:0] if_pc
);

  localparam logic [1:0] c_issue = 2'd0;
  localparam logic [1:0] c_wait  = 2'd1;
  localparam logic [1:0] c_hold  = 2'd2;
  localparam logic [1:0] c_drop  = 2'd3;

  localparam logic [N-1:0] c_align_mask = {{(N-2){1'b1}}, 2'b00};
  localparam logic [N-1:0] c_four       = N'(4);

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [N-1:0] r_pc;
  logic [N-1:0] r_fetch_pc;
  logic [31:0]  r_hold_instr;
  logic         r_if_valid;
  logic [31:0]  r_if_instr;
  logic [N-1:0] r_if_pc;

  logic [N-1:0] w_target;
  logic [N-1:0] w_pc_inc;
  logic         w_xfer;
  logic         w_out_free;
  logic         w_accept;
  logic         w_park;
  logic         w_unhold;

  assign w_target   = branch_target & c_align_mask;
  assign w_pc_inc   = r_pc + c_four;
  assign w_xfer     = r_if_valid && if_ready;
  assign w_out_free = !r_if_valid || if_ready;
  assign w_accept   = (r_state == c_wait) && imem_rvalid && !branch_taken && w_out_free;
  assign w_park     = (r_state == c_wait) && imem_rvalid && !branch_taken && !w_out_free;
  assign w_unhold   = (r_state == c_hold) && !branch_taken && w_xfer;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_issue;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_issue: w_state_nxt = branch_taken ? c_issue : c_wait;
      c_wait: begin
        if (branch_taken) begin
          w_state_nxt = imem_rvalid ? c_issue : c_drop;
        end else if (imem_rvalid) begin
          w_state_nxt = w_out_free ? c_issue : c_hold;
        end
      end
      c_hold: w_state_nxt = (branch_taken || w_xfer) ? c_issue : c_hold;
      // A branch in DROP only moves the PC; the owed response still has to drain.
      c_drop: w_state_nxt = imem_rvalid ? c_issue : c_drop;
      default: w_state_nxt = c_issue;
    endcase
  end

  always_comb begin
    imem_req  = reset && (r_state == c_issue) && !branch_taken;
    imem_addr = r_pc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (branch_taken) begin
      r_pc <= w_target;
    end else if (w_accept || w_unhold) begin
      r_pc <= w_pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc <= '0;
    end else if (imem_req) begin
      r_fetch_pc <= r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || branch_taken) begin
      r_hold_instr <= '0;
    end else if (w_park) begin
      r_hold_instr <= imem_rdata;
    end
  end

  // The held word belongs to fetch_pc, which is untouched until the next request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
    end else if (branch_taken) begin
      r_if_valid <= 1'b0;
    end else if (w_accept) begin
      r_if_valid <= 1'b1;
      r_if_instr <= imem_rdata;
      r_if_pc    <= r_fetch_pc;
    end else if (w_unhold) begin
      r_if_valid <= 1'b1;
      r_if_instr <= r_hold_instr;
      r_if_pc    <= r_fetch_pc;
    end else if (w_xfer) begin
      r_if_valid <= 1'b0;
    end
  end

  assign if_valid = r_if_valid;
  assign if_instr = r_if_instr;
  assign if_pc    = r_if_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit: directed bench with a queue-level fetch model.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'd0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'hDEADBEEF;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'd0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [63:0] if_pc;

  fetch_unit #(.N(64), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [63:0] a; } pend_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;

  pend_t pend[$];
  int    cycle = 0;
  int    lat = 1;
  int    total = 0;
  int    bad = 0;
  int    nreq_dut = 0, nreq_mod = 0, nxfer_dut = 0, nxfer_mod = 0;

  // Model: instructions fetched but not yet taken by decode, plus the request in flight.
  ent_t        mq[$];
  int          outst = 0;
  bit          stale = 0;
  bit          m_known = 0;
  logic [63:0] m_pc = 64'd0;
  logic [63:0] m_req_addr = 64'd0;

  logic        l_req, l_v;
  logic [63:0] l_addr, l_pc;
  logic [31:0] l_instr;

  function automatic logic [31:0] memw(input logic [63:0] a);
    if (a == 64'd0) return 32'hF8400020;
    if (a == 64'd4) return 32'hF8008021;
    return 32'hD000_0000 ^ a[31:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", nm, got, exp, cycle);
    end
  endtask

  task automatic cyc();
    bit exp_req;
    if (pend.size() > 0 && pend[0].due == cycle) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memw(pend[0].a);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEADBEEF;
    end
    @(negedge clk);
    l_req = imem_req; l_addr = imem_addr; l_v = if_valid; l_pc = if_pc; l_instr = if_instr;
    exp_req = reset && !branch_taken && outst == 0 && mq.size() < 2;
    if (m_known) begin
      chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      chk("if_valid", {63'd0, if_valid}, {63'd0, mq.size() > 0});
      if (mq.size() > 0) begin
        chk("if_pc", if_pc, mq[0].pc);
        chk("if_instr", {32'd0, if_instr}, {32'd0, mq[0].instr});
      end
    end
    if (imem_req === 1'b1) begin
      pend.push_back('{cycle + lat, imem_addr});
      nreq_dut++;
    end
    if (if_valid === 1'b1 && if_ready) nxfer_dut++;
    if (!reset) begin
      mq.delete(); outst = 0; stale = 0; m_pc = RST_PC; m_known = 1;
    end else if (branch_taken) begin
      if (mq.size() > 0 && if_ready) nxfer_mod++;
      mq.delete();
      if (outst != 0) begin
        if (imem_rvalid) begin outst = 0; stale = 0; end
        else stale = 1;
      end
      m_pc = branch_target & ~64'd3;
    end else begin
      if (mq.size() > 0 && if_ready) begin void'(mq.pop_front()); nxfer_mod++; end
      if (imem_rvalid && outst != 0) begin
        outst = 0;
        if (stale) stale = 0;
        else begin
          mq.push_back('{m_req_addr, imem_rdata});
          m_pc = m_req_addr + 64'd4;
        end
      end
      if (exp_req) begin outst = 1; m_req_addr = m_pc; nreq_mod++; end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic run_until_req(input string nm, input int maxc);
    bit seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      cyc();
      seen = (l_req === 1'b1);
    end
    chk({nm, "_req_seen"}, {63'd0, seen}, 64'd1);
  endtask

  task automatic run_until_valid(input string nm, input int maxc);
    bit seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      cyc();
      seen = (l_v === 1'b1);
    end
    chk({nm, "_valid_seen"}, {63'd0, seen}, 64'd1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) cyc();
    reset = 1'b1;
    chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_if_instr", {32'd0, if_instr}, 64'd0);
    chk("rst_if_pc", if_pc, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_v;
    int n;
    @(posedge clk); #1;

    // 1: streaming at latency 1, decode always ready
    lat = 1; if_ready = 1'b1;
    do_reset(2);
    cyc(); chk("t1_a_req", {63'd0, l_req}, 64'd1); chk("t1_a_addr", l_addr, 64'd0);
           chk("t1_a_v", {63'd0, l_v}, 64'd0);
    cyc(); chk("t1_b_req", {63'd0, l_req}, 64'd0);
    cyc(); chk("t1_c_req", {63'd0, l_req}, 64'd1); chk("t1_c_addr", l_addr, 64'd4);
           chk("t1_c_pc", l_pc, 64'd0); chk("t1_c_instr", {32'd0, l_instr}, 64'hF8400020);
    cyc(); chk("t1_d_req", {63'd0, l_req}, 64'd0); chk("t1_d_v", {63'd0, l_v}, 64'd0);
    cyc(); chk("t1_e_req", {63'd0, l_req}, 64'd1); chk("t1_e_addr", l_addr, 64'd8);
           chk("t1_e_pc", l_pc, 64'd4); chk("t1_e_instr", {32'd0, l_instr}, 64'hF8008021);
    for (int i = 0; i < 4; i++) cyc();

    // 2: backpressure parks the second word in the hold buffer
    if_ready = 1'b0;
    do_reset(1);
    cyc(); chk("t2_a_addr", l_addr, 64'd0);
    cyc();
    cyc(); chk("t2_c_addr", l_addr, 64'd4); chk("t2_c_pc", l_pc, 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2_hold_req", {63'd0, l_req}, 64'd0);
      chk("t2_hold_pc", l_pc, 64'd0);
    end
    if_ready = 1'b1;
    cyc(); chk("t2_h_req", {63'd0, l_req}, 64'd0); chk("t2_h_pc", l_pc, 64'd0);
    cyc(); chk("t2_i_pc", l_pc, 64'd4); chk("t2_i_instr", {32'd0, l_instr}, 64'hF8008021);
           chk("t2_i_req", {63'd0, l_req}, 64'd1); chk("t2_i_addr", l_addr, 64'd8);

    // 3: redirect while waiting on a latency-3 response
    for (int i = 0; i < 4; i++) cyc();
    lat = 3;
    do_reset(1);
    run_until_req("t3_0", 10);
    run_until_req("t3_4", 10);
    run_until_req("t3_8", 10); chk("t3_addr8", l_addr, 64'd8);
    branch_taken = 1'b1; branch_target = 64'h40;
    cyc();
    branch_taken = 1'b0;
    saw_v = 0; n = 0;
    for (int i = 0; i < 10 && l_req !== 1'b1; i++) begin
      cyc(); n++; saw_v |= (l_v === 1'b1);
    end
    chk("t3_drop_cycles", n, 3);
    chk("t3_no_valid", {63'd0, saw_v}, 64'd0);
    chk("t3_addr40", l_addr, 64'h40);

    // 4: branch coincides with the response for 0x40
    cyc(); cyc();
    branch_taken = 1'b1; branch_target = 64'h103;
    cyc();
    branch_taken = 1'b0;
    cyc(); chk("t4_req", {63'd0, l_req}, 64'd1); chk("t4_addr", l_addr, 64'h100);
           chk("t4_v", {63'd0, l_v}, 64'd0);

    // 5: branch during ISSUE suppresses that cycle's request
    cyc(); cyc(); cyc();
    branch_taken = 1'b1; branch_target = 64'h200;
    cyc(); chk("t5_issue_req", {63'd0, l_req}, 64'd0);
           chk("t5_issue_pc", l_pc, 64'h100);
    branch_taken = 1'b0;
    cyc(); chk("t5_req", {63'd0, l_req}, 64'd1); chk("t5_addr", l_addr, 64'h200);
    for (int i = 0; i < 8; i++) cyc();
    chk("t5_req_count", nreq_dut, nreq_mod);
    chk("t5_xfer_count", nxfer_dut, nxfer_mod);

    // 6a: reset in WAIT, stale response lands the cycle after release
    run_until_req("t6a", 10);
    reset = 1'b0; cyc(); cyc();
    reset = 1'b1;
    cyc(); chk("t6a_req", {63'd0, l_req}, 64'd1); chk("t6a_addr", l_addr, RST_PC);
    run_until_valid("t6a", 10);
    chk("t6a_pc", l_pc, 64'd0); chk("t6a_instr", {32'd0, l_instr}, 64'hF8400020);

    // 6b: stale response arrives while reset is held
    run_until_req("t6b", 10);
    reset = 1'b0; for (int i = 0; i < 4; i++) cyc();
    reset = 1'b1;
    cyc(); chk("t6b_addr", l_addr, RST_PC);
    run_until_valid("t6b", 10); chk("t6b_pc", l_pc, 64'd0);

    // 6c: pc wraps from the top of the address space
    lat = 1;
    for (int i = 0; i < 6; i++) cyc();
    run_until_req("t6c_pre", 10);
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFE;
    cyc();
    branch_taken = 1'b0;
    run_until_req("t6c_top", 10); chk("t6c_top_addr", l_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    run_until_req("t6c_wrap", 10); chk("t6c_wrap_addr", l_addr, 64'd0);
    chk("t6c_wrap_pc", l_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 4; i++) cyc();
    chk("end_req_count", nreq_dut, nreq_mod);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
